// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port arbiter and byte-lane aligner between the fetch
// stage / MEM stage and a unified instruction/data RAM.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_ack)
//   if_inst/if_ack                 fetched instruction + one-cycle ack
//   mem_req/mem_we/mem_op/         load/store request (held until mem_ack)
//   mem_addr/mem_wdata
//   mem_rdata/mem_ack/mem_err      extended load data, ack, misalign abort
//   stall_req                      any request pending and not yet acked
//   ram_*                          registered RAM access port controls
//
// RAM byte offset k lives at word bits [31-8k:24-8k] and is enabled by sel[k].
//
// Optional feature: define MEM_ARB_MISALIGN_TRAP_EN to abort misaligned
// H/W accesses with mem_err instead of truncating the low address bits.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        stall_req,
    output logic        ram_pc_ce,
    output logic        ram_mem_ce,
    output logic        ram_we,
    output logic        ram_who,
    output logic [31:0] ram_pc_addr,
    output logic [31:0] ram_mem_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_inst,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, MEM} state_t;

    state_t      state_q, state_d;
    logic        last_mem_q, last_mem_d;   // 1 = MEM port was served last
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;             // current MEM access is an abort
    logic        ram_pc_ce_q, ram_pc_ce_d;
    logic        ram_mem_ce_q, ram_mem_ce_d;
    logic        ram_we_q, ram_we_d;
    logic        ram_who_q, ram_who_d;
    logic [31:0] ram_pc_addr_q, ram_pc_addr_d;
    logic [31:0] ram_mem_addr_q, ram_mem_addr_d;
    logic [3:0]  ram_sel_q, ram_sel_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_ack_q, if_ack_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_ack_q, mem_ack_d;
    logic        mem_err_q, mem_err_d;

    logic        mis;
    logic        grant_mem;
    logic [1:0]  o;
    logic [3:0]  st_sel;
    logic [31:0] st_wdata;
    logic [31:0] sh_b, sh_h, ld_data;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign o = mem_addr[1:0];

`ifdef MEM_ARB_MISALIGN_TRAP_EN
    assign mis = ((mem_op[1:0] == 2'b01) & o[0]) | ((mem_op[1:0] == 2'b10) & (o != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Store lane placement; byte offset k sits at bits [31-8k -: 8], so the
    // shift towards bit 0 is (3-k) bytes, and 3-k == ~k for a 2-bit offset.
    always_comb begin
        st_sel   = 4'b1111;
        st_wdata = {mem_wdata[7:0], mem_wdata[15:8], mem_wdata[23:16], mem_wdata[31:24]};
        case (mem_op[1:0])
            2'b00: begin
                st_sel   = 4'b0001 << o;
                st_wdata = {24'h0, mem_wdata[7:0]} << {~o, 3'b000};
            end
            2'b01: begin
                // addr[0] is ignored: halves start at offset 0 or 2
                st_sel   = o[1] ? 4'b1100 : 4'b0011;
                st_wdata = {16'h0, mem_wdata[7:0], mem_wdata[15:8]} << {~o[1], 4'b0000};
            end
            default: ;
        endcase
    end

    // Load gather: inverse of the store placement, then extend.
    always_comb begin
        sh_b = ram_rdata >> {~off_q, 3'b000};
        sh_h = ram_rdata >> {~off_q[1], 4'b0000};
        ld_b = sh_b[7:0];
        ld_h = {sh_h[7:0], sh_h[15:8]};
        case (op_q)
            3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_data = {24'h0, ld_b};
            3'b101:  ld_data = {16'h0, ld_h};
            default: ld_data = {ram_rdata[7:0], ram_rdata[15:8], ram_rdata[23:16], ram_rdata[31:24]};
        endcase
    end

    always_comb begin
        state_d        = state_q;
        last_mem_d     = last_mem_q;
        op_d           = op_q;
        off_d          = off_q;
        err_d          = err_q;
        ram_pc_ce_d    = 1'b0;
        ram_mem_ce_d   = 1'b0;
        ram_we_d       = 1'b0;
        ram_who_d      = 1'b0;
        ram_pc_addr_d  = 32'h0;
        ram_mem_addr_d = 32'h0;
        ram_sel_d      = 4'h0;
        ram_wdata_d    = 32'h0;
        if_inst_d      = if_inst_q;
        if_ack_d       = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        mem_ack_d      = 1'b0;
        mem_err_d      = 1'b0;
        // Tie goes to the port not served last.
        grant_mem      = mem_req & (~if_req | ~last_mem_q);

        case (state_q)
            IDLE: begin
                // While an ack is out the requester may still be holding its
                // stale req; no grant is made in that turnaround cycle.
                if (!if_ack_q && !mem_ack_q) begin
                    if (grant_mem) begin
                        state_d    = MEM;
                        last_mem_d = 1'b1;
                        op_d       = mem_op;
                        off_d      = o;
                        err_d      = mis;
                        if (!mis) begin
                            ram_mem_ce_d   = 1'b1;
                            ram_who_d      = 1'b1;
                            ram_we_d       = mem_we;
                            ram_mem_addr_d = {mem_addr[31:2], 2'b00};
                            ram_sel_d      = mem_we ? st_sel : 4'h0;
                            ram_wdata_d    = mem_we ? st_wdata : 32'h0;
                        end
                    end else if (if_req) begin
                        state_d       = FETCH;
                        last_mem_d    = 1'b0;
                        ram_pc_ce_d   = 1'b1;
                        ram_pc_addr_d = if_addr;
                    end
                end
            end
            FETCH: begin
                if_inst_d = ram_inst;
                if_ack_d  = 1'b1;
                state_d   = IDLE;
            end
            MEM: begin
                mem_ack_d = 1'b1;
                state_d   = IDLE;
                if (err_q) begin
                    mem_err_d   = 1'b1;
                    mem_rdata_d = 32'h0;
                end else if (!ram_we_q) begin
                    mem_rdata_d = ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_mem_q     <= 1'b0;
            op_q           <= 3'h0;
            off_q          <= 2'h0;
            err_q          <= 1'b0;
            ram_pc_ce_q    <= 1'b0;
            ram_mem_ce_q   <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_who_q      <= 1'b0;
            ram_pc_addr_q  <= 32'h0;
            ram_mem_addr_q <= 32'h0;
            ram_sel_q      <= 4'h0;
            ram_wdata_q    <= 32'h0;
            if_inst_q      <= 32'h0;
            if_ack_q       <= 1'b0;
            mem_rdata_q    <= 32'h0;
            mem_ack_q      <= 1'b0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_mem_q     <= last_mem_d;
            op_q           <= op_d;
            off_q          <= off_d;
            err_q          <= err_d;
            ram_pc_ce_q    <= ram_pc_ce_d;
            ram_mem_ce_q   <= ram_mem_ce_d;
            ram_we_q       <= ram_we_d;
            ram_who_q      <= ram_who_d;
            ram_pc_addr_q  <= ram_pc_addr_d;
            ram_mem_addr_q <= ram_mem_addr_d;
            ram_sel_q      <= ram_sel_d;
            ram_wdata_q    <= ram_wdata_d;
            if_inst_q      <= if_inst_d;
            if_ack_q       <= if_ack_d;
            mem_rdata_q    <= mem_rdata_d;
            mem_ack_q      <= mem_ack_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign if_inst      = if_inst_q;
    assign if_ack       = if_ack_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_ack      = mem_ack_q;
    assign mem_err      = mem_err_q;
    assign ram_pc_ce    = ram_pc_ce_q;
    assign ram_mem_ce   = ram_mem_ce_q;
    assign ram_we       = ram_we_q;
    assign ram_who      = ram_who_q;
    assign ram_pc_addr  = ram_pc_addr_q;
    assign ram_mem_addr = ram_mem_addr_q;
    assign ram_sel      = ram_sel_q;
    assign ram_wdata    = ram_wdata_q;
    assign stall_req    = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-enabled RAM.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [2:0]  mem_op;
    logic [31:0] if_inst, mem_rdata;
    logic        if_ack, mem_ack, mem_err, stall_req;
    logic        ram_pc_ce, ram_mem_ce, ram_we, ram_who;
    logic [31:0] ram_pc_addr, ram_mem_addr, ram_wdata, ram_inst, ram_rdata;
    logic [3:0]  ram_sel;
    logic        preload;

    int errs = 0;
    int checks = 0;

    logic [3:0]  s_sel;
    logic [31:0] s_wd, s_addr;
    logic        s_mce;

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
        .stall_req(stall_req),
        .ram_pc_ce(ram_pc_ce), .ram_mem_ce(ram_mem_ce), .ram_we(ram_we), .ram_who(ram_who),
        .ram_pc_addr(ram_pc_addr), .ram_mem_addr(ram_mem_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_inst(ram_inst), .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // RAM model: offset k at bits [31-8k -: 8]; commits on the closing edge.
    assign ram_inst  = swap32(ram[ram_pc_addr[9:2]]);
    assign ram_rdata = ram[ram_mem_addr[9:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[2]    <= swap32(32'h00A00093);
            ram[8'h40] <= swap32(32'hCAFEF00D);
        end else if (ram_mem_ce && ram_we) begin
            for (int k = 0; k < 4; k++)
                if (ram_sel[k]) ram[ram_mem_addr[9:2]][31-8*k -: 8] <= ram_wdata[31-8*k -: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic do_mem(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat);
        int n;
        n = 0; lat = -1; rd = 32'h0; err = 1'b0;
        mem_req = 1'b1; mem_we = we; mem_op = op; mem_addr = addr; mem_wdata = wd;
        while (lat < 0 && n < 20) begin
            @(negedge clk);
            if (n == 1) begin
                s_sel = ram_sel; s_wd = ram_wdata; s_mce = ram_mem_ce; s_addr = ram_mem_addr;
            end
            if (mem_ack) begin
                lat = n; rd = mem_rdata; err = mem_err;
            end
            n++;
        end
        if (lat < 0) chk("mem_ack_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, n, t_mem, t_if;

    initial begin
        rst = 1'b1; preload = 1'b1;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_op = 3'b010;
        if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        @(posedge clk); #1 preload = 1'b0;
        @(negedge clk);
        chk("rst_outs", {31'h0, ram_pc_ce | ram_mem_ce | ram_we | ram_who | if_ack | mem_ack
                         | mem_err | stall_req}, 32'h0);
        chk("rst_buses", ram_pc_addr | ram_mem_addr | ram_wdata | {28'h0, ram_sel}
                         | if_inst | mem_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Fetch from 0x8
        if_req = 1'b1; if_addr = 32'h8; n = 0; lat = -1;
        while (lat < 0 && n < 20) begin
            @(negedge clk);
            if (n == 1) chk("fetch_pc_addr", ram_pc_addr, 32'h8);
            if (n == 1) chk("fetch_who", {31'h0, ram_who}, 32'h0);
            if (if_ack) begin
                lat = n;
                chk("fetch_inst", if_inst, 32'h00A00093);
                chk("fetch_stall", {31'h0, stall_req}, 32'h0);
            end
            n++;
        end
        chk("fetch_lat", lat, 2);
        @(posedge clk); #1 if_req = 1'b0;

        // Simultaneous fetch + LW 0x100: MEM wins the first tie
        if_req = 1'b1; if_addr = 32'h8;
        mem_req = 1'b1; mem_we = 1'b0; mem_op = 3'b010; mem_addr = 32'h100;
        n = 0; t_mem = -1; t_if = -1;
        while ((t_mem < 0 || t_if < 0) && n < 30) begin
            @(negedge clk);
            if (mem_ack) begin t_mem = n; chk("tie_lw_data", mem_rdata, 32'hCAFEF00D); end
            if (if_ack) t_if = n;
            n++;
            @(posedge clk); #1;
            if (t_mem >= 0) mem_req = 1'b0;
            if (t_if >= 0) if_req = 1'b0;
        end
        chk("tie_mem_ack_cyc", t_mem, 2);
        chk("tie_if_ack_cyc", t_if, 5);
        mem_req = 1'b0; if_req = 1'b0;

        // Misaligned LW 0x102
        do_mem(1'b0, 3'b010, 32'h102, 32'h0, rd, er, lat);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        chk("mis_err", {31'h0, er}, 32'h1);
        chk("mis_rdata", rd, 32'h0);
        chk("mis_ce", {31'h0, s_mce}, 32'h0);
`else
        chk("mis_err", {31'h0, er}, 32'h0);
        chk("mis_rdata", rd, 32'hCAFEF00D);
        chk("mis_addr", s_addr, 32'h100);
`endif

        // Byte stores and loads
        do_mem(1'b1, 3'b000, 32'h103, 32'h5A, rd, er, lat);
        chk("sb_sel", {28'h0, s_sel}, 32'h8);
        chk("sb_wdata", s_wd, 32'h0000005A);
        chk("sb_lat", lat, 2);
        do_mem(1'b0, 3'b100, 32'h103, 32'h0, rd, er, lat);
        chk("lbu", rd, 32'h5A);
        do_mem(1'b1, 3'b000, 32'h103, 32'hFF, rd, er, lat);
        do_mem(1'b0, 3'b000, 32'h103, 32'h0, rd, er, lat);
        chk("lb_neg", rd, 32'hFFFFFFFF);
        do_mem(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
        chk("lw_after_sb", rd, 32'hFFFEF00D);
        chk("if_inst_hold", if_inst, 32'h00A00093);

        // Word and half
        do_mem(1'b1, 3'b010, 32'h200, 32'h12345678, rd, er, lat);
        chk("sw_sel", {28'h0, s_sel}, 32'hF);
        chk("sw_wdata", s_wd, 32'h78563412);
        do_mem(1'b0, 3'b001, 32'h202, 32'h0, rd, er, lat);
        chk("lh_hi", rd, 32'h00001234);
        do_mem(1'b0, 3'b101, 32'h200, 32'h0, rd, er, lat);
        chk("lhu_lo", rd, 32'h00005678);
        do_mem(1'b1, 3'b001, 32'h202, 32'h8001, rd, er, lat);
        chk("sh_sel", {28'h0, s_sel}, 32'hC);
        chk("sh_wdata", s_wd, 32'h00000180);
        do_mem(1'b0, 3'b001, 32'h202, 32'h0, rd, er, lat);
        chk("lh_neg", rd, 32'hFFFF8001);
        do_mem(1'b0, 3'b010, 32'h200, 32'h0, rd, er, lat);
        chk("lw_after_sh", rd, 32'h80015678);

        // Reset during a store's access cycle
        mem_req = 1'b1; mem_we = 1'b1; mem_op = 3'b010; mem_addr = 32'h300; mem_wdata = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_st_ce_before", {31'h0, ram_mem_ce}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_st_ctl", {28'h0, ram_mem_ce, ram_we, ram_who, ram_pc_ce}, 32'h0);
        chk("rst_st_bus", ram_wdata | ram_mem_addr | {28'h0, ram_sel}, 32'h0);
        mem_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        do_mem(1'b0, 3'b010, 32'h300, 32'h0, rd, er, lat);
        chk("rst_no_commit", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
